// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the main-memory arbiter and the caches.
// The arbiter FSM states and the owner encoding live here so the cache blocks
// and the arbiter agree on them.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner selection between the I-cache and D-cache requests.
// Build option MEM_ARB_RR_EN: when defined, simultaneous requests alternate
// using the last granted owner; otherwise the D-cache always wins a tie.
import mem_arb_pkg::*;

module mem_arb_pick (
`ifdef MEM_ARB_RR_EN
    input  owner_t last_owner,
`endif
    input  logic   ic_req,
    input  logic   dc_req,
    output logic   any_req,
    output owner_t grant
);

    // Pick the owner; grant is only meaningful while any_req is high.
    always_comb begin
        any_req = ic_req | dc_req;
        grant   = OWN_D;
`ifdef MEM_ARB_RR_EN
        if (ic_req && dc_req) begin
            grant = (last_owner == OWN_D) ? OWN_I : OWN_D;
        end else if (ic_req) begin
            grant = OWN_I;
        end
`else
        if (!dc_req && ic_req) begin
            grant = OWN_I;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single main-memory port between the I-cache and D-cache.
// One transaction at a time: IDLE arbitrates, BUSY waits for mem_ack, RESP
// pulses the owner's done for one cycle. Build option MEM_ARB_RR_EN selects
// round-robin tie-breaking (see mem_arb_pick); default is D over I.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output state_t            dbg_state
);

    // Handshake: each requester holds req (level) until it sees its one-cycle
    // done; mem_req is held high until the single-cycle mem_ack. mem_ack is
    // only honoured in BUSY.

    state_t state_q, state_d;
    // Owner of the current/most recent transaction; it doubles as the
    // round-robin history when that option is built in.
    owner_t owner_q;
    logic   any_req;
    owner_t grant;

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .last_owner (owner_q),
`endif
        .ic_req     (ic_req),
        .dc_req     (dc_req),
        .any_req    (any_req),
        .grant      (grant)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; RESP never arbitrates, so a pending request waits a cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (mem_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request registers load on a grant and stay frozen through BUSY; read
    // data is captured into the owner's register on the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_I;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                owner_q <= grant;
                if (grant == OWN_D) begin
                    mem_we    <= dc_we;
                    mem_addr  <= dc_addr;
                    mem_wdata <= dc_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= ic_addr;
                    mem_wdata <= '0;
                end
            end
            // Writebacks leave dc_rdata untouched.
            if (state_q == BUSY && mem_ack && !mem_we) begin
                if (owner_q == OWN_D) dc_rdata <= mem_rdata;
                else                  ic_rdata <= mem_rdata;
            end
        end
    end

    // Outputs decoded from registered state so reset forces them low at once.
    assign mem_req   = (state_q == BUSY);
    assign ic_done   = (state_q == RESP) && (owner_q == OWN_I);
    assign dc_done   = (state_q == RESP) && (owner_q == OWN_D);
    assign dbg_state = state_q;

endmodule
